// File: rtl/multicycle_controlunit.sv
// rtl/multicycle_controlunit.sv - multi-cycle Moore control FSM with trap and retire counter
//
// Sequences each instruction through FETCH/DECODE/execute/memory/writeback
// for a shared-memory multi-cycle datapath. Decodes LW, SW, R-type
// (add/sub/and/or/slt), BEQ and ADDI; any other encoding parks the FSM in
// TRAP until reset.
//
// Ports (all prefixed multicycle_controlunit_):
//   clk, rst        clock, synchronous active-high reset
//   opcode, funct   instruction fields, held stable by the IR for the whole instruction
//   zero            ALU zero flag, qualifies the branch PC load
//   mem_ready       memory completes the current access this cycle
//   RegDst .. PCSrc datapath mux selects and write enables
//   alu_control     ALU operation
//   state           current FSM state, for debug
//   trap            sticky illegal-instruction flag
//   retired         completed-instruction count, wraps modulo 2^CNTW
module multicycle_controlunit #(
  parameter int OPW  = 6,
  parameter int FW   = 6,
  parameter int ACW  = 4,
  parameter int CNTW = 16,
  parameter logic [OPW-1:0] OP_RTYPE = 6'b000001,
  parameter logic [OPW-1:0] OP_LW    = 6'b000100,
  parameter logic [OPW-1:0] OP_SW    = 6'b000010,
  parameter logic [OPW-1:0] OP_BEQ   = 6'b000011,
  parameter logic [OPW-1:0] OP_ADDI  = 6'b001000
) (
  input  logic            multicycle_controlunit_clk,
  input  logic            multicycle_controlunit_rst,
  input  logic [OPW-1:0]  multicycle_controlunit_opcode,
  input  logic [FW-1:0]   multicycle_controlunit_funct,
  input  logic            multicycle_controlunit_zero,
  input  logic            multicycle_controlunit_mem_ready,
  output logic            multicycle_controlunit_RegDst,
  output logic            multicycle_controlunit_ALUSrcA,
  output logic [1:0]      multicycle_controlunit_ALUSrcB,
  output logic            multicycle_controlunit_MemToReg,
  output logic            multicycle_controlunit_RegWrite,
  output logic            multicycle_controlunit_MemRead,
  output logic            multicycle_controlunit_MemWrite,
  output logic            multicycle_controlunit_IorD,
  output logic            multicycle_controlunit_IRWrite,
  output logic            multicycle_controlunit_PCWrite,
  output logic            multicycle_controlunit_PCSrc,
  output logic [ACW-1:0]  multicycle_controlunit_alu_control,
  output logic [3:0]      multicycle_controlunit_state,
  output logic            multicycle_controlunit_trap,
  output logic [CNTW-1:0] multicycle_controlunit_retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTEXEC   = 4'd6,
    S_RTWB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [ACW-1:0] ALU_AND = ACW'(4'b0001);
  localparam logic [ACW-1:0] ALU_OR  = ACW'(4'b0010);
  localparam logic [ACW-1:0] ALU_ADD = ACW'(4'b0101);
  localparam logic [ACW-1:0] ALU_SUB = ACW'(4'b0110);
  localparam logic [ACW-1:0] ALU_SLT = ACW'(4'b0111);

  localparam logic [FW-1:0] F_ADD = FW'(6'b100000);
  localparam logic [FW-1:0] F_SUB = FW'(6'b100010);
  localparam logic [FW-1:0] F_AND = FW'(6'b100100);
  localparam logic [FW-1:0] F_OR  = FW'(6'b100101);
  localparam logic [FW-1:0] F_SLT = FW'(6'b101010);

  state_t         state_q;
  state_t         state_d;
  logic           funct_ok;
  logic [ACW-1:0] funct_alu;

  // R-type funct decode, shared by the DECODE legality check and the
  // RTEXEC/RTWB ALU selection.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = '0;
    case (multicycle_controlunit_funct)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_TRAP;
    case (state_q)
      S_FETCH:  state_d = multicycle_controlunit_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (multicycle_controlunit_opcode == OP_LW || multicycle_controlunit_opcode == OP_SW)
          state_d = S_MEMADDR;
        else if (multicycle_controlunit_opcode == OP_RTYPE)
          state_d = funct_ok ? S_RTEXEC : S_TRAP;
        else if (multicycle_controlunit_opcode == OP_BEQ)
          state_d = S_BRANCH;
        else if (multicycle_controlunit_opcode == OP_ADDI)
          state_d = S_ADDIEXEC;
        else
          state_d = S_TRAP;
      end
      // Opcode is still held by the IR, so it picks the load or store leg.
      S_MEMADDR: begin
        if (multicycle_controlunit_opcode == OP_LW)
          state_d = S_MEMRD;
        else if (multicycle_controlunit_opcode == OP_SW)
          state_d = S_MEMWR;
        else
          state_d = S_TRAP;
      end
      S_MEMRD:    state_d = multicycle_controlunit_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = multicycle_controlunit_mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXEC:   state_d = S_RTWB;
      S_RTWB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      default:    state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge multicycle_controlunit_clk) begin
    if (multicycle_controlunit_rst) begin
      state_q                        <= S_FETCH;
      multicycle_controlunit_trap    <= 1'b0;
      multicycle_controlunit_retired <= '0;
    end else begin
      state_q <= state_d;
      // Trap rises together with the state entering TRAP.
      if (state_d == S_TRAP)
        multicycle_controlunit_trap <= 1'b1;
      // Only the final state of an instruction can enter FETCH from outside
      // FETCH; TRAP never does, so trapped instructions are not counted.
      if (state_d == S_FETCH && state_q != S_FETCH)
        multicycle_controlunit_retired <= multicycle_controlunit_retired + 1'b1;
    end
  end

  assign multicycle_controlunit_state = state_q;

  always_comb begin
    multicycle_controlunit_RegDst      = 1'b0;
    multicycle_controlunit_ALUSrcA     = 1'b0;
    multicycle_controlunit_ALUSrcB     = 2'd0;
    multicycle_controlunit_MemToReg    = 1'b0;
    multicycle_controlunit_RegWrite    = 1'b0;
    multicycle_controlunit_MemRead     = 1'b0;
    multicycle_controlunit_MemWrite    = 1'b0;
    multicycle_controlunit_IorD        = 1'b0;
    multicycle_controlunit_IRWrite     = 1'b0;
    multicycle_controlunit_PCWrite     = 1'b0;
    multicycle_controlunit_PCSrc       = 1'b0;
    multicycle_controlunit_alu_control = '0;
    case (state_q)
      S_FETCH: begin
        multicycle_controlunit_MemRead     = 1'b1;
        multicycle_controlunit_ALUSrcB     = 2'd1;
        multicycle_controlunit_alu_control = ALU_ADD;
        // IR and PC+4 are captured only on the cycle the fetch completes.
        multicycle_controlunit_IRWrite     = multicycle_controlunit_mem_ready;
        multicycle_controlunit_PCWrite     = multicycle_controlunit_mem_ready;
      end
      S_DECODE: begin
        multicycle_controlunit_ALUSrcB     = 2'd3;
        multicycle_controlunit_alu_control = ALU_ADD;
      end
      S_MEMADDR, S_ADDIEXEC: begin
        multicycle_controlunit_ALUSrcA     = 1'b1;
        multicycle_controlunit_ALUSrcB     = 2'd2;
        multicycle_controlunit_alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        multicycle_controlunit_MemRead = 1'b1;
        multicycle_controlunit_IorD    = 1'b1;
      end
      S_MEMWB: begin
        multicycle_controlunit_RegWrite = 1'b1;
        multicycle_controlunit_MemToReg = 1'b1;
      end
      S_MEMWR: begin
        multicycle_controlunit_MemWrite = 1'b1;
        multicycle_controlunit_IorD     = 1'b1;
      end
      S_RTEXEC: begin
        multicycle_controlunit_ALUSrcA     = 1'b1;
        multicycle_controlunit_alu_control = funct_alu;
      end
      S_RTWB: begin
        multicycle_controlunit_RegWrite    = 1'b1;
        multicycle_controlunit_RegDst      = 1'b1;
        multicycle_controlunit_alu_control = funct_alu;
      end
      S_BRANCH: begin
        multicycle_controlunit_ALUSrcA     = 1'b1;
        multicycle_controlunit_alu_control = ALU_SUB;
        multicycle_controlunit_PCSrc       = 1'b1;
        multicycle_controlunit_PCWrite     = multicycle_controlunit_zero;
      end
      S_ADDIWB: multicycle_controlunit_RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// tb/tb_multicycle_controlunit.sv - self-checking bench for multicycle_controlunit
module tb_multicycle_controlunit;

  localparam int TB_CNTW = 2;

  localparam logic [5:0] OP_RTYPE = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic RegDst, ALUSrcA, MemToReg, RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc;
  logic [1:0] ALUSrcB;
  logic [3:0] alu_control;
  logic [3:0] state;
  logic trap;
  logic [TB_CNTW-1:0] retired;

  int errors = 0;
  int checks = 0;
  int model_ret = 0;

  typedef struct {
    int st;
    bit mr;
  } ent_t;

  multicycle_controlunit #(.CNTW(TB_CNTW)) dut (
    .multicycle_controlunit_clk(clk),
    .multicycle_controlunit_rst(rst),
    .multicycle_controlunit_opcode(opcode),
    .multicycle_controlunit_funct(funct),
    .multicycle_controlunit_zero(zero),
    .multicycle_controlunit_mem_ready(mem_ready),
    .multicycle_controlunit_RegDst(RegDst),
    .multicycle_controlunit_ALUSrcA(ALUSrcA),
    .multicycle_controlunit_ALUSrcB(ALUSrcB),
    .multicycle_controlunit_MemToReg(MemToReg),
    .multicycle_controlunit_RegWrite(RegWrite),
    .multicycle_controlunit_MemRead(MemRead),
    .multicycle_controlunit_MemWrite(MemWrite),
    .multicycle_controlunit_IorD(IorD),
    .multicycle_controlunit_IRWrite(IRWrite),
    .multicycle_controlunit_PCWrite(PCWrite),
    .multicycle_controlunit_PCSrc(PCSrc),
    .multicycle_controlunit_alu_control(alu_control),
    .multicycle_controlunit_state(state),
    .multicycle_controlunit_trap(trap),
    .multicycle_controlunit_retired(retired)
  );

  always #5 clk = ~clk;

  logic [15:0] ctrl;
  assign ctrl = {RegDst, ALUSrcA, ALUSrcB, MemToReg, RegWrite, MemRead, MemWrite,
                 IorD, IRWrite, PCWrite, PCSrc, alu_control};

  function automatic bit legal_funct(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0101;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0001;
      6'b100101: return 4'b0010;
      6'b101010: return 4'b0111;
      default:   return 4'b0000;
    endcase
  endfunction

  // Expected control word for a state, read off the per-state control table.
  function automatic logic [15:0] exp_ctrl(input int st, input bit mr, input bit z, input logic [5:0] fn);
    logic rd, sa, mtr, rw, mrd, mwr, iord, irw, pcw, pcs;
    logic [1:0] sb;
    logic [3:0] alu;
    {rd, sa, mtr, rw, mrd, mwr, iord, irw, pcw, pcs} = '0;
    sb = 2'd0;
    alu = 4'd0;
    if (st == 0) begin mrd = 1; sb = 1; alu = 4'b0101; irw = mr; pcw = mr; end
    if (st == 1) begin sb = 3; alu = 4'b0101; end
    if (st == 2 || st == 9) begin sa = 1; sb = 2; alu = 4'b0101; end
    if (st == 3) begin mrd = 1; iord = 1; end
    if (st == 4) begin rw = 1; mtr = 1; end
    if (st == 5) begin mwr = 1; iord = 1; end
    if (st == 6) begin sa = 1; alu = alu_of(fn); end
    if (st == 7) begin rw = 1; rd = 1; alu = alu_of(fn); end
    if (st == 8) begin sa = 1; alu = 4'b0110; pcs = 1; pcw = z; end
    if (st == 10) rw = 1;
    return {rd, sa, sb, mtr, rw, mrd, mwr, iord, irw, pcw, pcs, alu};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ret = 0;
  endtask

  // Drives one instruction cycle by cycle from the expected state path built
  // from the instruction class and stall counts; starts and ends in FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input int sf, input int sm);
    ent_t q[$];
    bit trapped = 0;
    opcode = op;
    funct = fn;
    zero = z;
    for (int i = 0; i < sf; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom)});
    if (op == OP_LW) begin
      q.push_back('{2, 1'($urandom)});
      for (int i = 0; i < sm; i++) q.push_back('{3, 1'b0});
      q.push_back('{3, 1'b1});
      q.push_back('{4, 1'($urandom)});
    end else if (op == OP_SW) begin
      q.push_back('{2, 1'($urandom)});
      for (int i = 0; i < sm; i++) q.push_back('{5, 1'b0});
      q.push_back('{5, 1'b1});
    end else if (op == OP_RTYPE && legal_funct(fn)) begin
      q.push_back('{6, 1'($urandom)});
      q.push_back('{7, 1'($urandom)});
    end else if (op == OP_BEQ) begin
      q.push_back('{8, 1'($urandom)});
    end else if (op == OP_ADDI) begin
      q.push_back('{9, 1'($urandom)});
      q.push_back('{10, 1'($urandom)});
    end else begin
      trapped = 1;
      for (int i = 0; i < 10; i++) q.push_back('{15, 1'($urandom)});
    end
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      #1;
      checks++;
      if (state !== 4'(q[i].st)) begin
        errors++;
        $display("FAIL %s cyc%0d state got=%0d exp=%0d", name, i, state, q[i].st);
      end
      checks++;
      if (ctrl !== exp_ctrl(q[i].st, q[i].mr, z, fn)) begin
        errors++;
        $display("FAIL %s cyc%0d ctrl got=%h exp=%h", name, i, ctrl, exp_ctrl(q[i].st, q[i].mr, z, fn));
      end
      checks++;
      if (trap !== (q[i].st == 15)) begin
        errors++;
        $display("FAIL %s cyc%0d trap got=%0b exp=%0b", name, i, trap, q[i].st == 15);
      end
      checks++;
      if (retired !== TB_CNTW'(model_ret)) begin
        errors++;
        $display("FAIL %s cyc%0d retired got=%0d exp=%0d", name, i, retired, TB_CNTW'(model_ret));
      end
      @(negedge clk);
    end
    if (!trapped) begin
      model_ret++;
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || retired !== TB_CNTW'(model_ret)) begin
        errors++;
        $display("FAIL %s end state=%0d retired=%0d exp state=0 retired=%0d",
                 name, state, retired, TB_CNTW'(model_ret));
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || trap !== 1'b0 || retired !== '0) begin
      errors++;
      $display("FAIL %s state=%0d trap=%0b retired=%0d exp 0/0/0", name, state, trap, retired);
    end
    checks++;
    if (ctrl !== exp_ctrl(0, 1'b0, 1'b0, 6'd0)) begin
      errors++;
      $display("FAIL %s ctrl got=%h exp=%h", name, ctrl, exp_ctrl(0, 1'b0, 1'b0, 6'd0));
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_state("reset_initial");
    opcode = OP_LW;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();
    check_reset_state("reset_mid_instr");
  endtask

  task automatic test_lw();
    do_reset();
    run_instr("lw", OP_LW, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_sw_stall();
    run_instr("sw_stall", OP_SW, 6'd0, 1'b0, 0, 3);
  endtask

  task automatic test_rtype();
    run_instr("rt_sub", OP_RTYPE, 6'b100010, 1'b0, 0, 0);
    run_instr("rt_slt", OP_RTYPE, 6'b101010, 1'b1, 1, 0);
    run_instr("rt_bad", OP_RTYPE, 6'b000000, 1'b0, 0, 0);
    do_reset();
    check_reset_state("reset_after_rt_trap");
  endtask

  task automatic test_beq();
    run_instr("beq_taken", OP_BEQ, 6'd0, 1'b1, 0, 0);
    run_instr("beq_not_taken", OP_BEQ, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'b111111, 6'd0, 1'b0, 0, 0);
    do_reset();
    check_reset_state("reset_mid_trap");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) run_instr("addi_wrap", OP_ADDI, 6'($urandom), 1'($urandom), 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops[5];
    logic [5:0] fns[5];
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < 30; i++) begin
      run_instr("random", ops[$urandom_range(0, 4)], fns[$urandom_range(0, 4)],
                1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_beq();
    test_illegal();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controlunit.md
Name: multicycle_controlunit

Overview:
Parametrised multi-cycle successor to the single-cycle control decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback, with memory-ready stalls. It adds ADDI and BEQ, full R-type funct decode, a sticky trap on illegal encodings and a retired-instruction counter. It sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
OPW, 6, opcode width
FW, 6, funct width
ACW, 4, ALU control width
CNTW, 16, retired-instruction counter width
OP_RTYPE, 6'b000001, R-type opcode
OP_LW, 6'b000100, load-word opcode
OP_SW, 6'b000010, store-word opcode
OP_BEQ, 6'b000011, branch-if-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode

Ports:
multicycle_controlunit_clk  in  1  clock; all state changes on the rising edge
multicycle_controlunit_rst  in  1  synchronous reset, active-high
multicycle_controlunit_opcode  in  OPW  opcode field from the instruction register
multicycle_controlunit_funct  in  FW  funct field from the instruction register
multicycle_controlunit_zero  in  1  ALU zero flag
multicycle_controlunit_mem_ready  in  1  memory completes the current access this cycle
multicycle_controlunit_RegDst  out  1  1 = rd, 0 = rt
multicycle_controlunit_ALUSrcA  out  1  0 = PC, 1 = register A
multicycle_controlunit_ALUSrcB  out  2  0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate shifted left 2
multicycle_controlunit_MemToReg  out  1  writeback source is memory data
multicycle_controlunit_RegWrite  out  1  register file write enable
multicycle_controlunit_MemRead  out  1  memory read request
multicycle_controlunit_MemWrite  out  1  memory write request
multicycle_controlunit_IorD  out  1  0 = PC address, 1 = ALUOut address
multicycle_controlunit_IRWrite  out  1  instruction register load
multicycle_controlunit_PCWrite  out  1  PC load; already qualified by branch condition
multicycle_controlunit_PCSrc  out  1  0 = ALU result, 1 = ALUOut (branch target)
multicycle_controlunit_alu_control  out  ACW  ALU operation
multicycle_controlunit_state  out  4  current state, for debug
multicycle_controlunit_trap  out  1  sticky illegal-instruction flag
multicycle_controlunit_retired  out  CNTW  count of completed instructions

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, TRAP=15. Any unused encoding goes to TRAP.
- Reset, synchronous: state=FETCH, trap=0, retired=0. Reset has priority over every other event, including mid-instruction and in TRAP.
- Outputs are combinational from state only, except where noted. Every signal not listed for a state is 0.
- ALU codes: ADD=0101, SUB=0110, AND=0001, OR=0010, SLT=0111.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, alu=ADD.
  - IRWrite=PCWrite=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, alu=ADD (branch target into ALUOut).
  - Next state by opcode: LW/SW->MEMADDR, RTYPE->RTEXEC, BEQ->BRANCH, ADDI->ADDIEXEC, otherwise->TRAP.
  - For RTYPE with a funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}, next state is TRAP.
- MEMADDR: ALUSrcA=1, ALUSrcB=2, alu=ADD. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH.
- RTEXEC: ALUSrcA=1, ALUSrcB=0, alu from funct (add->ADD, sub->SUB, and->AND, or->OR, slt->SLT). Next state RTWB.
- RTWB: RegWrite=1, RegDst=1, alu held from funct. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, alu=SUB, PCSrc=1, PCWrite=zero. Next state FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=2, alu=ADD. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0. Next state FETCH.
- TRAP:
  - All enables are 0; trap=1 registered, set on entry.
  - TRAP is absorbing; only reset leaves it.
- Latency without stalls: LW 5 cycles, SW 4, R-type 4, ADDI 4, BEQ 3.
- Each added mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTWB, BRANCH or ADDIWB, whether the branch is taken or not. It wraps modulo 2^CNTW and does not increment on a trap.
- opcode and funct must be stable from DECODE until the instruction returns to FETCH; the FSM does not latch them.

Test Plan:
- Reset: hold rst=1 for 2 cycles in any state -> state=0, trap=0, retired=0; FETCH outputs with MemRead=1, ALUSrcB=1, alu=0101.
- LW, mem_ready=1 always: opcode=000100 -> state sequence 0,1,2,3,4,0. MEMWB shows RegWrite=1 and MemToReg=1. retired goes 0->1.
- SW with 3 stall cycles: mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, IorD=1, then FETCH. Total latency 7 cycles.
- R-type sweep: funct=100010 -> RTEXEC alu=0110, RTWB RegDst=1, RegWrite=1. funct=101010 -> alu=0111. funct=000000 -> TRAP, trap=1, retired unchanged.
- BEQ: zero=1 -> PCWrite=1, PCSrc=1 in BRANCH. zero=0 -> PCWrite=0. Both return to FETCH in 3 cycles with retired +1.
- Illegal opcode 111111 -> TRAP held for 10 cycles with all enables 0. Reset mid-TRAP -> FETCH. Counter wrap: with CNTW=2, 4 ADDIs -> retired 1,2,3,0.
